// File: rtl/piezo_alarm_seq.sv
// Priority-based multi-alarm melody sequencer driving a complementary piezo pair.
// Optional feature macro PIEZO_ACK_EN adds an ack input that mutes the playing alarm until its request drops.
module piezo_alarm_seq #(
  parameter int NUM_ALARMS = 3,
  parameter int NOTES = 4,
  parameter int HP_W = 16,
  parameter logic [NUM_ALARMS*NOTES*HP_W-1:0] NOTE_HP = {12{16'd25000}},
  parameter int NOTE_DUR_CYC = 2**23,
  parameter int GAP_CYC = 2**25,
  parameter int FAST_SIM = 0,
  parameter int FAST_SHIFT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_ALARMS-1:0] alarm_req,
`ifdef PIEZO_ACK_EN
  input  logic                  ack,
`endif
  output logic                  piezo,
  output logic                  piezo_n,
  output logic                  active,
  output logic [(NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1)-1:0] cur_alarm
);

  localparam int AW      = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
  localparam int NW      = NOTES > 1 ? $clog2(NOTES) : 1;
  localparam int ENTRIES = NUM_ALARMS * NOTES;
  localparam int DUR_RAW = (FAST_SIM != 0) ? (NOTE_DUR_CYC >> FAST_SHIFT) : NOTE_DUR_CYC;
  localparam int GAP_RAW = (FAST_SIM != 0) ? (GAP_CYC >> FAST_SHIFT) : GAP_CYC;
  localparam int DUR_N   = DUR_RAW < 1 ? 1 : DUR_RAW;
  localparam int GAP_N   = GAP_RAW < 1 ? 1 : GAP_RAW;
  localparam int DUR_W   = DUR_N > 1 ? $clog2(DUR_N) : 1;
  localparam int GAP_W   = GAP_N > 1 ? $clog2(GAP_N) : 1;

  localparam logic [DUR_W-1:0] DUR_LAST  = DUR_W'(DUR_N - 1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_N - 1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [NW-1:0]    NOTE_LAST = NW'(NOTES - 1);
  localparam logic [NW-1:0]    NOTE_ONE  = NW'(1);
  localparam logic [HP_W-1:0]  HP_ONE    = HP_W'(1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t            state, state_d;
  logic [AW-1:0]     cur_d;
  logic [NW-1:0]     note, note_d;
  logic [DUR_W-1:0]  dur_cnt, dur_d;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic [HP_W-1:0]   hp_cnt, hp_d, hp_cur;
  logic              piezo_d, piezo_n_d;
  logic [NUM_ALARMS-1:0] eligible;
  logic [AW-1:0]     top;
  logic              req_any, gap_done, start;

`ifdef PIEZO_ACK_EN
  logic [NUM_ALARMS-1:0] muted, muted_d;
  logic                  gap_zero, gap_zero_d, ack_hit;
`endif

  // The table is written a0n0 first, so entry 0 occupies the most significant field.
  function automatic logic [HP_W-1:0] hp_of(input logic [AW-1:0] a, input logic [NW-1:0] n);
    int e;
    e = int'(a) * NOTES + int'(n);
    return NOTE_HP[(ENTRIES-1-e)*HP_W +: HP_W];
  endfunction

  function automatic logic [AW-1:0] top_idx(input logic [NUM_ALARMS-1:0] r);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (r[i]) idx = AW'(i);
    return idx;
  endfunction

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latches).
  always_comb begin
`ifdef PIEZO_ACK_EN
    eligible = alarm_req & ~muted;
    ack_hit  = ack && (state != IDLE);
    gap_done = (gap_cnt == GAP_LAST) || gap_zero;
`else
    eligible = alarm_req;
    gap_done = (gap_cnt == GAP_LAST);
`endif
    req_any = |eligible;
    top     = top_idx(eligible);
    hp_cur  = hp_of(cur_alarm, note);

    state_d = state;
    cur_d   = cur_alarm;
    note_d  = note;
    dur_d   = dur_cnt;
    hp_d    = hp_cnt;
    gap_d   = gap_cnt;
    piezo_d = 1'b0;
    start   = 1'b0;

    case (state)
      IDLE: start = req_any;
      PLAY: begin
        if (req_any && top > cur_alarm) begin
          start = 1'b1;
        end else if (dur_cnt == DUR_LAST) begin
          dur_d = '0;
          hp_d  = '0;
          if (note == NOTE_LAST) begin
            state_d = GAP;
            gap_d   = '0;
            note_d  = '0;
          end else begin
            note_d = note + NOTE_ONE;
          end
        end else begin
          dur_d = dur_cnt + DUR_ONE;
          if (hp_cur != '0) begin
            if (hp_cnt == hp_cur - HP_ONE) begin
              hp_d    = '0;
              piezo_d = ~piezo;
            end else begin
              hp_d    = hp_cnt + HP_ONE;
              piezo_d = piezo;
            end
          end
        end
      end
      GAP: begin
        if (req_any && (top > cur_alarm || gap_done)) begin
          start = 1'b1;
        end else if (gap_done) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_cnt + GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = PLAY;
      cur_d   = top;
      note_d  = '0;
      dur_d   = '0;
      hp_d    = '0;
      gap_d   = '0;
      piezo_d = 1'b0;
    end

`ifdef PIEZO_ACK_EN
    muted_d    = muted & alarm_req;
    gap_zero_d = (state_d == GAP) && gap_zero;
    if (ack_hit) begin
      muted_d[cur_alarm] = 1'b1;
      if (!start) begin
        state_d    = GAP;
        gap_d      = '0;
        gap_zero_d = 1'b1;
        note_d     = '0;
        dur_d      = '0;
        hp_d       = '0;
        piezo_d    = 1'b0;
      end
    end
`endif

    // Complement is driven only while a tone sounds, so the transducer never sees DC.
    piezo_n_d = (state_d == PLAY) && (hp_of(cur_d, note_d) != '0) && !piezo_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_alarm <= '0;
      note      <= '0;
      dur_cnt   <= '0;
      hp_cnt    <= '0;
      gap_cnt   <= '0;
      piezo     <= 1'b0;
      piezo_n   <= 1'b0;
`ifdef PIEZO_ACK_EN
      muted     <= '0;
      gap_zero  <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cur_alarm <= cur_d;
      note      <= note_d;
      dur_cnt   <= dur_d;
      hp_cnt    <= hp_d;
      gap_cnt   <= gap_d;
      piezo     <= piezo_d;
      piezo_n   <= piezo_n_d;
`ifdef PIEZO_ACK_EN
      muted     <= muted_d;
      gap_zero  <= gap_zero_d;
`endif
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_piezo_alarm_seq.sv
// Directed bench for piezo_alarm_seq: expected {piezo,piezo_n,active,cur_alarm} samples are
// queued per cycle as stimulus is driven and compared on the falling edge when that cycle arrives.
module tb_piezo_alarm_seq;

  localparam logic [95:0] HP_TABLE = {16'd5, 16'd0, 16'd10, 16'd20, 16'd40, 16'd8};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alarm_req;
  logic       piezo, piezo_n, active;
  logic [1:0] cur_alarm;
`ifdef PIEZO_ACK_EN
  logic       ack;
`endif

  int cyc = 0;
  int t0 = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    int         at;
    logic [4:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  piezo_alarm_seq #(
    .NUM_ALARMS(3), .NOTES(2), .HP_W(16), .NOTE_HP(HP_TABLE),
    .NOTE_DUR_CYC(400), .GAP_CYC(800), .FAST_SIM(0), .FAST_SHIFT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alarm_req(alarm_req),
`ifdef PIEZO_ACK_EN
    .ack(ack),
`endif
    .piezo(piezo),
    .piezo_n(piezo_n),
    .active(active),
    .cur_alarm(cur_alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int at, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc+%0d: got p,pn,act,cur=%b required %b", tag, at - t0, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, e.at, {piezo, piezo_n, active, cur_alarm}, e.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int off, input logic p, input logic pn, input logic act,
                      input logic [1:0] cur, input string tag);
    sb.push_back('{at: t0 + off, exp: {p, pn, act, cur}, tag: tag});
  endtask

  // A sounding note: piezo_n is the complement of the expected phase.
  task automatic push_tone(input int off, input int phase, input logic [1:0] cur, input string tag);
    logic p;
    p = (phase % 2) != 0;
    push(off, p, ~p, 1'b1, cur, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alarm_req = 3'b000;
`ifdef PIEZO_ACK_EN
    ack = 1'b0;
`endif
    step(3);
    check("reset_values", cyc, {piezo, piezo_n, active, cur_alarm}, 5'b00000);
    rst = 1'b0;
    step(2);

    // Alarm 0 for one clock: half-period 5 note, then a rest, then the gap, then idle.
    t0 = cyc;
    alarm_req = 3'b001;
    for (int k = 1; k <= 400; k++) push_tone(k, (k - 1) / 5, 2'd0, "t1_note0_hp5");
    push(401, 1'b0, 1'b0, 1'b1, 2'd0, "t1_rest_start");
    push(800, 1'b0, 1'b0, 1'b1, 2'd0, "t1_rest_end");
    push(801, 1'b0, 1'b0, 1'b1, 2'd0, "t1_gap_start");
    push(1600, 1'b0, 1'b0, 1'b1, 2'd0, "t1_gap_end");
    push(1601, 1'b0, 1'b0, 1'b0, 2'd0, "t1_idle");
    step(1);
    alarm_req = 3'b000;
    step(1610);

    // Alarms 0 and 1 held: alarm 1 plays, replays after the gap, and finishes after its request drops.
    t0 = cyc;
    alarm_req = 3'b011;
    for (int k = 1; k <= 400; k++) push_tone(k, (k - 1) / 10, 2'd1, "t2_note0_hp10");
    for (int k = 401; k <= 800; k++) push_tone(k, (k - 401) / 20, 2'd1, "t2_note1_hp20");
    push(801, 1'b0, 1'b0, 1'b1, 2'd1, "t2_gap_start");
    push(1600, 1'b0, 1'b0, 1'b1, 2'd1, "t2_gap_end");
    push_tone(1601, 0, 2'd1, "t2_replay_start");
    push_tone(1611, 1, 2'd1, "t2_replay_edge");
    push_tone(2400, 1, 2'd1, "t2_no_truncation");
    push(2401, 1'b0, 1'b0, 1'b1, 2'd1, "t2_gap_after_drop");
    push(3200, 1'b0, 1'b0, 1'b1, 2'd1, "t2_gap2_end");
    push(3201, 1'b0, 1'b0, 1'b0, 2'd1, "t2_idle_keeps_cur");
    step(1700);
    alarm_req = 3'b000;
    step(1505);

    // Alarm 0 preempted by alarm 2; alarm 1 waits for re-arbitration; reset mid-note.
    t0 = cyc;
    alarm_req = 3'b001;
    push_tone(1, 0, 2'd0, "t3_a0_start");
    push_tone(5, 0, 2'd0, "t3_a0_before_edge");
    push_tone(6, 1, 2'd0, "t3_a0_first_edge");
    push_tone(100, 1, 2'd0, "t3_a0_before_preempt");
    push_tone(101, 0, 2'd2, "t3_preempt_starts_low");
    push_tone(140, 0, 2'd2, "t3_a2_before_edge");
    push_tone(141, 1, 2'd2, "t3_a2_first_edge");
    push_tone(201, 0, 2'd2, "t4_lower_no_preempt");
    push_tone(221, 1, 2'd2, "t4_still_a2");
    push_tone(500, 1, 2'd2, "t3_a2_note0_end");
    push_tone(501, 0, 2'd2, "t3_a2_note1_start");
    push_tone(509, 1, 2'd2, "t3_a2_note1_edge");
    push_tone(900, 1, 2'd2, "t4_a2_finishes");
    push(901, 1'b0, 1'b0, 1'b1, 2'd2, "t4_gap_start");
    push(1700, 1'b0, 1'b0, 1'b1, 2'd2, "t4_gap_end");
    push_tone(1701, 0, 2'd1, "t4_a1_after_gap");
    push_tone(1711, 1, 2'd1, "t5_tone_high_before_rst");
    step(100);
    alarm_req = 3'b101;
    step(100);
    alarm_req = 3'b111;
    step(100);
    alarm_req = 3'b011;
    step(1401);
    alarm_req = 3'b000;
    step(10);
    rst = 1'b1;
    #1;
    check("t5_async_reset", cyc, {piezo, piezo_n, active, cur_alarm}, 5'b00000);
    step(2);
    rst = 1'b0;
    t0 = cyc;
    push(1, 1'b0, 1'b0, 1'b0, 2'd0, "t5_idle_after_rst");
    push(50, 1'b0, 1'b0, 1'b0, 2'd0, "t5_stays_idle");
    step(60);

`ifdef PIEZO_ACK_EN
    // Ack mutes alarm 1 while it is held; dropping and re-raising it plays again.
    t0 = cyc;
    alarm_req = 3'b010;
    push_tone(1, 0, 2'd1, "t6_start");
    push_tone(50, 0, 2'd1, "t6_before_ack");
    push(51, 1'b0, 1'b0, 1'b1, 2'd1, "t6_ack_gap");
    push(52, 1'b0, 1'b0, 1'b0, 2'd1, "t6_muted_idle");
    push(200, 1'b0, 1'b0, 1'b0, 2'd1, "t6_no_replay");
    step(50);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(149);
    alarm_req = 3'b000;
    step(2);
    t0 = cyc;
    alarm_req = 3'b010;
    push_tone(1, 0, 2'd1, "t6_replays");
    push_tone(11, 1, 2'd1, "t6_replay_edge");
    step(15);
    alarm_req = 3'b000;
`endif

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
